// File: rtl/ahbl_sram_subordinate.sv
// AHB-Lite subordinate backed by a word-addressed register-file memory.
// Supports byte/halfword/word writes, a fixed number of wait states per
// OKAY data phase, and the two-cycle ERROR response for bad transfers.
module ahbl_sram_subordinate #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          NWORDS      = 256,
    parameter int          WAIT_STATES = 0
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [1:0]  HTRANS,
    input  logic [2:0]  HBURST,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA
);

    localparam int AW = $clog2(NWORDS);
    localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t          state;
    logic [AW+1:0]   addr_q;
    logic            write_q;
    logic [1:0]      size_q;
    logic [3:0]      wait_cnt;
    logic [3:0]      byte_en;
    logic [AW-1:0]   word_idx;
    logic [31:0]     mem [NWORDS];

    logic accept;
    logic size_err;
    logic align_err;
    logic range_err;
    logic xfer_err;

    // Burst type and the BUSY/SEQ distinction play no part in decoding.
    logic unused_inputs;
    assign unused_inputs = ^{HBURST, HTRANS[0]};

    assign accept    = HSEL & HREADY & HTRANS[1];
    assign size_err  = (HSIZE > 3'd2);
    assign align_err = ((HSIZE == 3'd1) && HADDR[0]) ||
                       ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00));
    // Base is aligned to the region size, so the upper address bits identify it.
    assign range_err = (HADDR[31:AW+2] != BASE_ADDR[31:AW+2]);
    assign xfer_err  = size_err | align_err | range_err;

    assign word_idx  = addr_q[AW+1:2];

    // Transfer FSM; HREADYOUT/HRESP are registered alongside the state.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state     <= ST_IDLE;
            addr_q    <= '0;
            write_q   <= 1'b0;
            size_q    <= 2'd0;
            wait_cnt  <= 4'd0;
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b0;
        end else begin
            case (state)
                ST_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state     <= ST_DATA;
                        HREADYOUT <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ST_ERR1: begin
                    state     <= ST_ERR2;
                    HREADYOUT <= 1'b1;
                    HRESP     <= 1'b1;
                end
                // IDLE, DATA and ERR2 all end with HREADY high, so they take a new address phase.
                default: begin
                    if (accept) begin
                        addr_q  <= HADDR[AW+1:0];
                        write_q <= HWRITE;
                        size_q  <= HSIZE[1:0];
                        if (xfer_err) begin
                            state     <= ST_ERR1;
                            HREADYOUT <= 1'b0;
                            HRESP     <= 1'b1;
                        end else if (WAIT_STATES > 0) begin
                            state     <= ST_WAIT;
                            wait_cnt  <= WAIT_INIT;
                            HREADYOUT <= 1'b0;
                            HRESP     <= 1'b0;
                        end else begin
                            state     <= ST_DATA;
                            HREADYOUT <= 1'b1;
                            HRESP     <= 1'b0;
                        end
                    end else begin
                        state     <= ST_IDLE;
                        HREADYOUT <= 1'b1;
                        HRESP     <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Little-endian byte lane enables from the latched size and low address bits.
    always_comb begin
        // NOTE: default assignment first so every path assigns byte_en and no latch is inferred.
        byte_en = 4'b0000;
        case (size_q)
            2'd0:    byte_en = 4'b0001 << addr_q[1:0];
            2'd1:    byte_en = addr_q[1] ? 4'b1100 : 4'b0011;
            default: byte_en = 4'b1111;
        endcase
    end

    // Commit write data on the edge that closes a write data phase.
    // NOTE: the array has no reset branch; contents survive reset and map to plain storage.
    always_ff @(posedge HCLK) begin
        if (HRESETn && (state == ST_DATA) && write_q) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[word_idx][8*i +: 8] <= HWDATA[8*i +: 8];
                end
            end
        end
    end

    assign HRDATA = ((state == ST_DATA) && !write_q) ? mem[word_idx] : 32'h0000_0000;

endmodule

// File: tb/tb_ahbl_sram_subordinate.sv
// Bench for ahbl_sram_subordinate: two instances (zero-wait and three-wait)
// behind a small bus-mux model, driven by pipelined AHB-Lite beats with a
// scoreboard of expected data-phase responses.
module tb_ahbl_sram_subordinate;

    typedef struct {
        string       tag;
        logic [31:0] rdata;
        logic        resp;
        int          waits;
    } exp_t;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        hsel;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [1:0]  htrans;
    logic [2:0]  hburst;
    logic [31:0] hwdata;
    logic        sel;

    logic        hsel0, hsel1;
    logic        ro0, ro1, resp0, resp1;
    logic [31:0] rdata0, rdata1;
    logic        hready, bus_resp;
    logic [31:0] bus_rdata;

    int          errors = 0;
    int          checks = 0;
    exp_t        sb[$];
    bit          dp_valid;
    logic [31:0] dp_wdata;

    assign hsel0     = hsel & ~sel;
    assign hsel1     = hsel & sel;
    assign hready    = sel ? ro1 : ro0;
    assign bus_resp  = sel ? resp1 : resp0;
    assign bus_rdata = sel ? rdata1 : rdata0;

    ahbl_sram_subordinate #(.BASE_ADDR(32'h0000_0000), .NWORDS(64), .WAIT_STATES(0)) dut0 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel0), .HADDR(haddr), .HWRITE(hwrite),
        .HSIZE(hsize), .HTRANS(htrans), .HBURST(hburst), .HWDATA(hwdata), .HREADY(hready),
        .HREADYOUT(ro0), .HRESP(resp0), .HRDATA(rdata0)
    );

    ahbl_sram_subordinate #(.BASE_ADDR(32'h0000_1000), .NWORDS(16), .WAIT_STATES(3)) dut1 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel1), .HADDR(haddr), .HWRITE(hwrite),
        .HSIZE(hsize), .HTRANS(htrans), .HBURST(hburst), .HWDATA(hwdata), .HREADY(hready),
        .HREADYOUT(ro1), .HRESP(resp1), .HRDATA(rdata1)
    );

    always #5 HCLK = ~HCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Run cycles until the current data phase closes; score it if one is pending.
    task automatic complete_dp();
        int  lows = 0;
        bit  done = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge HCLK);
            if (hready === 1'b1) begin
                if (dp_valid) begin
                    exp_t e = sb.pop_front();
                    check({e.tag, "_rdata"}, bus_rdata, e.rdata);
                    check({e.tag, "_resp"}, {31'd0, bus_resp}, {31'd0, e.resp});
                    check({e.tag, "_waits"}, 32'(lows), 32'(e.waits));
                end
                done = 1;
            end else begin
                lows++;
                if (dp_valid) check({sb[0].tag, "_resp_low"}, {31'd0, bus_resp}, {31'd0, sb[0].resp});
            end
            @(posedge HCLK);
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL data_phase_timeout: observed=%0d low cycles expected=completion", lows);
        end
    endtask

    // Drive one address phase (pipelined with the previous data phase).
    task automatic beat(input logic [1:0] trans, input logic [31:0] addr, input logic wr,
                        input logic [2:0] size, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_resp,
                        input int exp_waits, input string tag);
        exp_t e;
        hsel   = 1'b1;
        htrans = trans;
        haddr  = addr;
        hwrite = wr;
        hsize  = size;
        hwdata = dp_wdata;
        complete_dp();
        if (trans[1]) begin
            e.tag   = tag;
            e.rdata = exp_rdata;
            e.resp  = exp_resp;
            e.waits = exp_waits;
            sb.push_back(e);
            dp_valid = 1;
            dp_wdata = wdata;
        end else begin
            dp_valid = 0;
            dp_wdata = 32'h0;
        end
        #1;
        hwdata = dp_wdata;
    endtask

    task automatic idle();
        beat(2'b00, 32'h0, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 0, "idle");
    endtask

    initial begin
        HRESETn = 1'b0;
        hsel = 1'b0; haddr = '0; hwrite = 1'b0; hsize = 3'd0; htrans = 2'b00;
        hburst = 3'd0; hwdata = '0; sel = 1'b0; dp_valid = 0; dp_wdata = '0;

        // Reset with HSEL low.
        repeat (3) @(posedge HCLK);
        #1 HRESETn = 1'b1;
        @(posedge HCLK);
        @(negedge HCLK);
        check("rst_rdy0", {31'd0, ro0}, 32'd1);
        check("rst_resp0", {31'd0, resp0}, 32'd0);
        check("rst_rdata0", rdata0, 32'h0);
        check("rst_rdy1", {31'd0, ro1}, 32'd1);
        check("rst_resp1", {31'd0, resp1}, 32'd0);
        check("rst_rdata1", rdata1, 32'h0);
        @(posedge HCLK);
        #1;

        // Zero-wait write then pipelined read of the same word.
        beat(2'b10, 32'h10, 1'b1, 3'd2, 32'hDEADBEEF, 32'h0, 1'b0, 0, "w_dead");
        beat(2'b10, 32'h10, 1'b0, 3'd2, 32'h0, 32'hDEADBEEF, 1'b0, 0, "r_dead");

        // Byte and halfword lane writes.
        beat(2'b10, 32'h10, 1'b1, 3'd2, 32'h11223344, 32'h0, 1'b0, 0, "w_base");
        beat(2'b11, 32'h13, 1'b1, 3'd0, 32'hAA5A5A5A, 32'h0, 1'b0, 0, "w_byte3");
        beat(2'b10, 32'h10, 1'b0, 3'd2, 32'h0, 32'hAA223344, 1'b0, 0, "r_byte3");
        beat(2'b10, 32'h10, 1'b1, 3'd1, 32'h99995566, 32'h0, 1'b0, 0, "w_half0");
        beat(2'b10, 32'h10, 1'b0, 3'd2, 32'h0, 32'hAA225566, 1'b0, 0, "r_half0");
        beat(2'b10, 32'hFC, 1'b1, 3'd2, 32'hCAFEF00D, 32'h0, 1'b0, 0, "w_last");
        beat(2'b10, 32'hFC, 1'b0, 3'd2, 32'h0, 32'hCAFEF00D, 1'b0, 0, "r_last");

        // Error responses: misaligned, out of range, bad size, errored write.
        beat(2'b10, 32'h02, 1'b0, 3'd2, 32'h0, 32'h0, 1'b1, 1, "e_misalign");
        beat(2'b10, 32'h100, 1'b0, 3'd2, 32'h0, 32'h0, 1'b1, 1, "e_range");
        beat(2'b10, 32'h10, 1'b0, 3'd3, 32'h0, 32'h0, 1'b1, 1, "e_size");
        beat(2'b10, 32'h11, 1'b1, 3'd2, 32'hFFFFFFFF, 32'h0, 1'b1, 1, "e_write");
        beat(2'b10, 32'h10, 1'b0, 3'd2, 32'h0, 32'hAA225566, 1'b0, 0, "r_after_err");
        idle();

        // Three-wait-state instance at a nonzero base.
        sel = 1'b1;
        beat(2'b10, 32'h1020, 1'b1, 3'd2, 32'h12345678, 32'h0, 1'b0, 3, "w3_word");
        beat(2'b10, 32'h1020, 1'b0, 3'd2, 32'h0, 32'h12345678, 1'b0, 3, "r3_word");
        beat(2'b10, 32'h1040, 1'b0, 3'd2, 32'h0, 32'h0, 1'b1, 1, "e3_range");
        idle();

        // Reset during a wait cycle drops the pending write.
        hsel = 1'b1; htrans = 2'b10; haddr = 32'h1020; hwrite = 1'b1; hsize = 3'd2;
        @(posedge HCLK);
        #1;
        htrans = 2'b00;
        hwdata = 32'hFFFFFFFF;
        @(negedge HCLK);
        check("t6_in_wait", {31'd0, ro1}, 32'd0);
        HRESETn = 1'b0;
        @(posedge HCLK);
        #1 HRESETn = 1'b1;
        @(negedge HCLK);
        check("t6_rdy", {31'd0, ro1}, 32'd1);
        check("t6_resp", {31'd0, resp1}, 32'd0);
        check("t6_rdata", rdata1, 32'h0);
        @(posedge HCLK);
        #1;
        dp_valid = 0;
        dp_wdata = 32'h0;
        beat(2'b10, 32'h1020, 1'b0, 3'd2, 32'h0, 32'h12345678, 1'b0, 3, "r3_after_rst");
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
